// File: rtl/lsu_pkg.sv
// Shared types and geometry for the load/store alignment unit.
// Memory is 32 words of four byte lanes, addressed by a 7-bit byte address.
package lsu_pkg;

  localparam int LANES   = 4;
  localparam int LANE_W  = 8;
  localparam int WORD_W  = LANES * LANE_W;
  localparam int ADDR_W  = 7;
  localparam int WADDR_W = 5;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC1 = 2'b01,
    ST_ACC2 = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  function automatic logic [2:0] size_bytes(input size_e sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  // Sign- or zero-extend a gathered load result to the full word.
  function automatic logic [WORD_W-1:0] extend_load(input size_e sz, input logic uns,
                                                    input logic [WORD_W-1:0] v);
    case (sz)
      SZ_BYTE: extend_load = uns ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      SZ_HALF: extend_load = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: extend_load = v;
    endcase
  endfunction

endpackage

// File: rtl/lane_rotate.sv
// Byte-lane rotator: input byte i appears on output lane (i + amt) mod 4.
// Rotating left by (4 - o) therefore gathers lane (o + i) mod 4 into byte i.
import lsu_pkg::*;

module lane_rotate (
  input  logic [WORD_W-1:0] data_i,
  input  logic [1:0]        amt_i,
  output logic [WORD_W-1:0] data_o
);

  logic [1:0] dst;

  always_comb begin
    data_o = '0;
    dst    = '0;
    for (int i = 0; i < LANES; i++) begin
      dst = 2'(i) + amt_i;
      data_o[{dst, 3'b000} +: LANE_W] = data_i[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit: splits misaligned accesses into two word
// accesses on a byte-lane memory and routes/gathers bytes through lane_rotate.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// ACC1  | access to the word holding the first byte
// ACC2  | access to the following word (misaligned only, wraps 31 -> 0)
// RESP  | response presented until rsp_ready
import lsu_pkg::*;

module lsu_align (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [WORD_W-1:0]  req_wdata,
  output logic [LANES-1:0]   mem_cs,
  output logic [WADDR_W-1:0] mem_addr,
  output logic               mem_we,
  output logic [WORD_W-1:0]  mem_wdata,
  input  logic [LANE_W-1:0]  mem_rdata0,
  input  logic [LANE_W-1:0]  mem_rdata1,
  input  logic [LANE_W-1:0]  mem_rdata2,
  input  logic [LANE_W-1:0]  mem_rdata3,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WORD_W-1:0]  rsp_rdata,
  output logic               rsp_err
);

  state_e              state_q;
  logic                we_q;
  size_e               size_q;
  logic                uns_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [WORD_W-1:0]   gath_q, gath_d;
  logic [WORD_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

  logic [1:0]          off;
  logic [2:0]          nbytes;
  logic [2:0]          last;
  logic                misaligned;
  logic [LANES-1:0]    cs_acc1, cs_acc2;
  logic                in_acc;
  logic [WORD_W-1:0]   wdata_rot;
  logic [WORD_W-1:0]   rd_word, rd_rot;
  logic [LANES-1:0]    byte_mask;
  logic [1:0]          ln;

  assign off        = addr_q[1:0];
  assign nbytes     = size_bytes(size_q);
  assign last       = {1'b0, off} + nbytes - 3'd1;
  assign misaligned = ({1'b0, off} + nbytes) > 3'd4;
  assign in_acc     = (state_q == ST_ACC1) || (state_q == ST_ACC2);

  always_comb begin
    cs_acc1 = '0;
    cs_acc2 = '0;
    for (int k = 0; k < LANES; k++) begin
      cs_acc1[k] = (3'(k) >= {1'b0, off}) && (3'(k) <= last);
      cs_acc2[k] = misaligned && (3'(k) <= (last - 3'd4));
    end
  end

  lane_rotate u_store_rot (
    .data_i (wdata_q),
    .amt_i  (off),
    .data_o (wdata_rot)
  );

  assign rd_word = {mem_rdata3, mem_rdata2, mem_rdata1, mem_rdata0};

  lane_rotate u_load_rot (
    .data_i (rd_word),
    .amt_i  (2'd0 - off),
    .data_o (rd_rot)
  );

  always_comb begin
    mem_cs    = '0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      ST_ACC1: begin
        mem_cs   = cs_acc1;
        mem_addr = addr_q[ADDR_W-1:2];
      end
      ST_ACC2: begin
        mem_cs   = cs_acc2;
        mem_addr = addr_q[ADDR_W-1:2] + 5'd1;
      end
      default: ;
    endcase
    if (in_acc) begin
      mem_we    = we_q;
      mem_wdata = wdata_rot;
    end
  end

  // Result byte i comes from lane (o + i) mod 4, only when that lane is selected.
  always_comb begin
    gath_d    = gath_q;
    byte_mask = '0;
    ln        = '0;
    for (int i = 0; i < LANES; i++) begin
      ln           = 2'(i) + off;
      byte_mask[i] = mem_cs[ln];
      if (byte_mask[i]) gath_d[i*LANE_W +: LANE_W] = rd_rot[i*LANE_W +: LANE_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gath_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= size_e'(req_size);
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            gath_q  <= '0;
            if (size_e'(req_size) == SZ_RSVD) begin
              state_q     <= ST_RESP;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q <= ST_ACC1;
            end
          end
        end
        ST_ACC1: begin
          gath_q <= gath_d;
          if (misaligned) begin
            state_q <= ST_ACC2;
          end else begin
            state_q     <= ST_RESP;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= we_q ? '0 : extend_load(size_q, uns_q, gath_d);
          end
        end
        ST_ACC2: begin
          gath_q      <= gath_d;
          state_q     <= ST_RESP;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= we_q ? '0 : extend_load(size_q, uns_q, gath_d);
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
